// File: rtl/agc.sv
`default_nettype none
// ============================================================================
// Module   : agc
// Brief    : Automatic gain control. Scales each decimated sample by a
//            programmable gain. Averages output magnitude over a 2^k window
//            and steps the gain toward a target magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module agc #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 24,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int GAIN_WIDTH = 16,
    parameter int GAIN_FRAC  = 12
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic                         WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]        Addr_DI,
    input  logic [MEM_WIDTH-1:0]         PAR_In_DI,
    input  logic signed [IN_WIDTH-1:0]   AGC_In_DI,
    input  logic                         AGC_Valid_DI,
    output logic signed [OUT_WIDTH-1:0]  AGC_Out_DO,
    output logic                         AGC_Valid_DO,
    output logic [GAIN_WIDTH-1:0]        AGC_Gain_DO,
    output logic                         AGC_Lock_DO
);

    localparam int c_NUM_ENTRIES = 2 ** ADDR_WIDTH;
    localparam int c_PROD_W      = IN_WIDTH + GAIN_WIDTH + 1;
    localparam int c_MAG_W       = OUT_WIDTH - 1;
    localparam int c_ACC_W       = 34;
    localparam int c_CNT_W       = 11;
    localparam logic [3:0] c_K_MAX = 4'd10;
    localparam logic [GAIN_WIDTH-1:0] c_UNITY = GAIN_WIDTH'(1) << GAIN_FRAC;
    localparam logic signed [c_PROD_W-1:0] c_SAT_HI =
        {{(c_PROD_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_PROD_W-1:0] c_SAT_LO =
        {{(c_PROD_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_UPDATE   = 2'd2
    } state_t;

    logic [MEM_WIDTH-1:0]  r_mem [c_NUM_ENTRIES];
    state_t                r_state, w_state_nxt;
    logic signed [OUT_WIDTH-1:0] r_out;
    logic                  r_valid;
    logic [GAIN_WIDTH-1:0] r_gain, w_gain_nxt;
    logic                  r_lock, w_lock_nxt;
    logic [c_ACC_W-1:0]    r_acc, w_acc_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;

    // Decoded parameter fields
    logic                  w_enable, w_freeze;
    logic [c_MAG_W-1:0]    w_target, w_hyst;
    logic [GAIN_WIDTH-1:0] w_step, w_gmin, w_gmax, w_init;
    logic [3:0]            w_k;

    assign w_enable = r_mem[0][0];
    assign w_freeze = r_mem[0][1];
    assign w_target = r_mem[1][c_MAG_W-1:0];
    assign w_hyst   = r_mem[2][c_MAG_W-1:0];
    assign w_step   = r_mem[3][GAIN_WIDTH-1:0];
    assign w_gmin   = r_mem[4][GAIN_WIDTH-1:0];
    assign w_gmax   = (r_mem[5][GAIN_WIDTH-1:0] == '0) ? {GAIN_WIDTH{1'b1}}
                                                        : r_mem[5][GAIN_WIDTH-1:0];
    assign w_init   = (r_mem[6][GAIN_WIDTH-1:0] == '0) ? c_UNITY
                                                        : r_mem[6][GAIN_WIDTH-1:0];
    assign w_k      = (r_mem[7][3:0] > c_K_MAX) ? c_K_MAX : r_mem[7][3:0];

    // Parameter memory: cleared on reset, written word-wise
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < c_NUM_ENTRIES; i++) r_mem[i] <= '0;
        end else if (WrEn_SI) begin
            r_mem[Addr_DI] <= PAR_In_DI;
        end
    end

    // Gain multiply, floor shift and saturation
    logic signed [c_PROD_W-1:0] w_in_ext, w_gain_ext, w_prod, w_shift;
    logic signed [OUT_WIDTH-1:0] w_sat;

    assign w_in_ext   = {{(c_PROD_W-IN_WIDTH){AGC_In_DI[IN_WIDTH-1]}}, AGC_In_DI};
    assign w_gain_ext = {{(c_PROD_W-GAIN_WIDTH){1'b0}}, r_gain};
    assign w_prod     = w_in_ext * w_gain_ext;
    assign w_shift    = w_prod >>> GAIN_FRAC;

    // Clip the shifted product into the output range
    always_comb begin
        if (w_shift > c_SAT_HI)      w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (w_shift < c_SAT_LO) w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else                         w_sat = w_shift[OUT_WIDTH-1:0];
    end

    // Output sample register; holds between strobes
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= AGC_Valid_DI;
            if (AGC_Valid_DI) r_out <= w_sat;
        end
    end

    // Magnitude of the presented output; the most negative code folds to max
    logic [OUT_WIDTH-1:0] w_neg;
    logic [c_MAG_W-1:0]   w_mag;

    assign w_neg = -r_out;
    assign w_mag = !r_out[OUT_WIDTH-1]            ? r_out[c_MAG_W-1:0] :
                   (r_out[c_MAG_W-1:0] == '0)     ? {c_MAG_W{1'b1}}    :
                                                    w_neg[c_MAG_W-1:0];

    // Window bookkeeping and the gain decision for the update cycle
    logic [c_CNT_W-1:0]  w_cnt_inc, w_win;
    logic                w_win_done;
    logic [c_ACC_W-1:0]  w_avg;
    logic [c_MAG_W:0]    w_hi;
    logic signed [c_MAG_W+1:0] w_lo;
    logic                w_above, w_below;
    logic [GAIN_WIDTH:0] w_g, w_g_lo;
    logic [GAIN_WIDTH-1:0] w_g_clamp;

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_win      = {{(c_CNT_W-1){1'b0}}, 1'b1} << w_k;
    assign w_win_done = (w_cnt_inc >= w_win);
    assign w_avg      = r_acc >> w_k;
    assign w_hi       = {1'b0, w_target} + {1'b0, w_hyst};
    assign w_lo       = $signed({2'b00, w_target}) - $signed({2'b00, w_hyst});
    assign w_above    = w_avg > {{(c_ACC_W-c_MAG_W-1){1'b0}}, w_hi};
    assign w_below    = !w_lo[c_MAG_W+1] &&
                        (w_avg < {{(c_ACC_W-c_MAG_W-2){1'b0}}, w_lo});
    assign w_g        = w_above ? ((r_gain > w_step) ? {1'b0, r_gain - w_step} : '0) :
                        w_below ? ({1'b0, r_gain} + {1'b0, w_step}) :
                                  {1'b0, r_gain};
    assign w_g_lo     = (w_g < {1'b0, w_gmin}) ? {1'b0, w_gmin} : w_g;
    assign w_g_clamp  = (w_g_lo > {1'b0, w_gmax}) ? w_gmax : w_g_lo[GAIN_WIDTH-1:0];

    // State register and AGC loop registers
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_state <= ST_DISABLED;
            r_gain  <= c_UNITY;
            r_lock  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_lock  <= w_lock_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and loop-register update; a cleared enable overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_lock_nxt  = r_lock;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_DISABLED: begin
                w_state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (r_valid) begin
                    w_acc_nxt = r_acc + {{(c_ACC_W-c_MAG_W){1'b0}}, w_mag};
                    if (w_win_done) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_UPDATE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            ST_UPDATE: begin
                if (!w_freeze) begin
                    w_gain_nxt = w_g_clamp;
                    w_lock_nxt = !w_above && !w_below;
                end
                // A sample presented during the update opens the next window
                if (r_valid) begin
                    w_acc_nxt = {{(c_ACC_W-c_MAG_W){1'b0}}, w_mag};
                    w_cnt_nxt = {{(c_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                end
                w_state_nxt = ST_ACCUM;
            end
            default: begin
                w_state_nxt = ST_DISABLED;
            end
        endcase
        if (!w_enable) begin
            w_state_nxt = ST_DISABLED;
            w_gain_nxt  = w_init;
            w_lock_nxt  = 1'b0;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
        end
    end

    // Fold bits that carry no meaning into one sink
    logic w_unused;
    always_comb begin
        w_unused = w_neg[OUT_WIDTH-1];
        for (int i = 0; i < c_NUM_ENTRIES; i++) w_unused = w_unused ^ (^r_mem[i]);
    end

    assign AGC_Out_DO   = r_out;
    assign AGC_Valid_DO = r_valid;
    assign AGC_Gain_DO  = r_gain;
    assign AGC_Lock_DO  = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_agc.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc
// Brief    : Scoreboard bench for agc. Stimulus pushes the expected output
//            and its arrival cycle; a monitor pops on every output strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_en;
    logic [4:0]         addr;
    logic [23:0]        par;
    logic signed [23:0] din;
    logic               din_vld;
    logic signed [23:0] dout;
    logic               dout_vld;
    logic [15:0]        gain;
    logic               lock;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;

    agc dut (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .WrEn_SI      (wr_en),
        .Addr_DI      (addr),
        .PAR_In_DI    (par),
        .AGC_In_DI    (din),
        .AGC_Valid_DI (din_vld),
        .AGC_Out_DO   (dout),
        .AGC_Valid_DO (dout_vld),
        .AGC_Gain_DO  (gain),
        .AGC_Lock_DO  (lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every output strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (dout_vld) begin
            if (q.size() == 0) begin
                chk("unexpected_out_strobe", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_value", $signed(dout), e.val);
                chk("out_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [23:0] d);
        wr_en = 1'b1;
        addr  = a;
        par   = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic send(input int x, input int exp);
        exp_t t;
        t.val = exp;
        t.cyc = cyc + 1;
        q.push_back(t);
        din     = x[23:0];
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; addr = '0; par = '0; din = '0; din_vld = 1'b0;
        idle(3);
        chk("rst_out", dout, 0);
        chk("rst_valid", dout_vld, 0);
        chk("rst_gain", gain, 4096);
        chk("rst_lock", lock, 0);
        rst_n = 1'b1;
        idle(2);

        // Pass-through while disabled
        send(100, 100);
        idle(2);
        send(-100, -100);
        idle(2);
        chk("passthru_gain", gain, 4096);
        chk("passthru_lock", lock, 0);

        // Gain step up: avg 500 below target 1000
        wr(1, 24'd1000); wr(2, 24'd0); wr(3, 24'd256);
        wr(4, 24'd1024); wr(5, 24'd16384); wr(7, 24'd2);
        wr(0, 24'd1);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            send(500, 500);
            idle(7);
        end
        idle(2);
        chk("step_up_gain", gain, 4352);
        chk("step_up_lock", lock, 0);
        send(500, 531);
        idle(3);
        send(-500, -532);
        idle(3);

        // Lock inside the band
        wr(0, 24'd0);
        wr(1, 24'd500); wr(2, 24'd10);
        idle(1);
        chk("disable_restores_init", gain, 4096);
        wr(0, 24'd1);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            send(500, 500);
            idle(3);
        end
        idle(3);
        chk("lock_gain", gain, 4096);
        chk("lock_set", lock, 1);

        // Saturation and gmax clamp
        wr(0, 24'd0);
        wr(6, 24'd16384); wr(5, 24'd16384); wr(1, 24'h7FFFFF); wr(2, 24'd0); wr(7, 24'd1);
        idle(2);
        chk("init_gain_loaded", gain, 16384);
        wr(0, 24'd1);
        idle(2);
        send(32'sh007FFFFF, 8388607);
        idle(2);
        send(-8388608, -8388608);
        idle(4);
        chk("sat_gain_held", gain, 16384);
        chk("sat_lock", lock, 1);

        // Back-to-back strobes across window boundaries
        wr(0, 24'd0);
        wr(6, 24'd0); wr(1, 24'd1000); wr(2, 24'd0); wr(7, 24'd1);
        idle(2);
        wr(0, 24'd1);
        idle(2);
        send(400, 400);
        send(400, 400);
        send(400, 400);
        send(400, 400);
        send(400, 425);
        idle(4);
        chk("b2b_gain_two_updates", gain, 4608);
        send(400, 450);
        idle(4);
        chk("b2b_carried_sample_gain", gain, 4864);

        // Freeze holds the gain through a full window
        wr(0, 24'd3);
        idle(1);
        send(400, 475);
        idle(2);
        send(400, 475);
        idle(4);
        chk("freeze_gain", gain, 4864);
        chk("freeze_lock", lock, 0);

        // Shrinking k mid-window closes it on the next sample; step down
        wr(0, 24'd0);
        wr(7, 24'd4);
        wr(0, 24'd1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            send(400, 400);
            idle(2);
        end
        wr(7, 24'd1);
        idle(2);
        chk("k_shrink_no_early_update", gain, 4096);
        send(400, 400);
        idle(4);
        chk("k_shrink_step_down", gain, 3840);
        chk("k_shrink_lock", lock, 0);
        send(400, 375);
        idle(2);

        // Dropping enable mid-window restores init gain on the next edge
        wr(0, 24'd0);
        chk("pre_drop_gain", gain, 3840);
        tick();
        chk("drop_enable_gain", gain, 4096);
        send(400, 400);
        idle(2);

        // Reset mid-stream with a strobe present
        din     = 24'd1234;
        din_vld = 1'b1;
        rst_n   = 1'b0;
        tick();
        chk("midrst_out", dout, 0);
        chk("midrst_valid", dout_vld, 0);
        chk("midrst_gain", gain, 4096);
        chk("midrst_lock", lock, 0);
        din_vld = 1'b0;
        rst_n   = 1'b1;
        idle(3);

        chk("pending_outputs", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agc.md
# agc

Automatic gain control stage that sits directly downstream of the Nyquist decimation filter. It consumes the filter's decimated sample stream and valid strobe, and scales each sample by a programmable-range gain. It also measures mean output magnitude over a power-of-two window and steps the gain up or down toward a programmed target. It uses the standard block parameter-memory write interface.

## Interface
Parameters:
- ADDR_WIDTH, 5, parameter memory address width (32 entries)
- MEM_WIDTH, 24, parameter word width
- IN_WIDTH, 24, signed input sample width
- OUT_WIDTH, 24, signed output sample width
- GAIN_WIDTH, 16, unsigned gain width
- GAIN_FRAC, 12, gain fractional bits (unity = 4096)

Ports. One clock; reset is synchronous and active-low.
- Clk_CI  in  1  clock
- Rst_RBI  in  1  synchronous active-low reset
- WrEn_SI  in  1  parameter write enable
- Addr_DI  in  ADDR_WIDTH  parameter address
- PAR_In_DI  in  MEM_WIDTH  parameter data
- AGC_In_DI  in  IN_WIDTH  signed sample, driven by the Nyquist filter output
- AGC_Valid_DI  in  1  input strobe, driven by the Nyquist valid pulse
- AGC_Out_DO  out  OUT_WIDTH  signed scaled sample
- AGC_Valid_DO  out  1  one-cycle pulse marking a new AGC_Out_DO
- AGC_Gain_DO  out  GAIN_WIDTH  current gain
- AGC_Lock_DO  out  1  last update fell inside the target band

## Operation
- **Parameter memory**
  - 32 x MEM_WIDTH, all entries cleared on reset, written when WrEn_SI=1.
  - Writes take effect on the next cycle, including while enabled.
- **Memory map**
  - addr0: bit0 enable, bit1 freeze.
  - addr1: target magnitude [22:0].
  - addr2: hysteresis [22:0].
  - addr3: step [15:0].
  - addr4: gmin [15:0].
  - addr5: gmax [15:0]; 0 means 0xFFFF.
  - addr6: init gain [15:0]; 0 means 4096.
  - addr7: log2 window k [3:0], clamped to 10.
- **Datapath**
  - prod = AGC_In_DI (signed) x gain (unsigned), 40-bit.
  - Arithmetic shift right by GAIN_FRAC (floor).
  - Saturate to [-2^23, 2^23-1].
  - mag = |out|; -2^23 maps to 2^23-1.
  - 34-bit accumulator acc; 11-bit sample counter cnt.
- **FSM states:** DISABLED, ACCUM, UPDATE.
- **DISABLED**
  - Entered when enable=0 (from any state).
  - Each cycle: gain <= init gain; acc, cnt, Lock cleared.
  - Samples still pass through at the init gain.
  - Goes to ACCUM when enable=1.
- **ACCUM**
  - On AGC_Valid_DO=1: acc += mag, cnt += 1.
  - When the incremented cnt >= 2^k: cnt <= 0 and go to UPDATE.
  - Using >= makes a mid-window reduction of k close the window on the next sample.
- **UPDATE (single cycle)**
  - avg = acc >> k.
  - If avg > target+hyst: g = gain-step (no underflow below 0). Lock=0.
  - Else if avg < target-hyst (computed signed; negative means never): g = gain+step (17-bit, no wrap). Lock=0.
  - Else: g = gain. Lock=1.
  - gain <= min(max(g, gmin), effective gmax), so gmax wins if gmin > gmax.
  - If freeze=1: gain and Lock unchanged.
  - acc <= 0. If AGC_Valid_DO=1 in this cycle, acc <= mag and cnt <= 1 instead.
  - Return to ACCUM (or DISABLED if enable=0).

## Timing
- **Reset values:** AGC_Out_DO=0, AGC_Valid_DO=0, AGC_Gain_DO=4096, AGC_Lock_DO=0; state DISABLED.
- **Latency**
  - Each AGC_Valid_DI produces AGC_Out_DO and AGC_Valid_DO=1 on the next edge (1 cycle).
  - AGC_Out_DO holds its value between strobes.
- **Back-to-back strobes:** accepted every cycle with no stall and no backpressure.
- **Gain sampling:** the product uses the gain register value in the cycle AGC_Valid_DI is high.
- **Gain update timing**
  - A gain update lands 2 edges after the window's last AGC_Valid_DO.
  - The new gain applies to inputs strobed from the cycle after UPDATE.
- **AGC_Gain_DO:** equals the gain register value.
- **Reset mid-window:** reset asserted mid-window clears everything on the next edge regardless of strobes.

## Test plan
- **Reset and pass-through.** Reset, then stream 100 and -100 with enable=0.
  - Outputs 100, -100, each 1 cycle after strobe; gain 4096; Lock 0.
- **Gain step up.** enable=1, k=2, target=1000, hyst=0, step=256, gmin=1024, gmax=16384; feed constant 500 every 8 cycles.
  - After the 4th sample, gain becomes 4352.
  - Next outputs are 531; an input of -500 gives -532.
- **Lock.** target=500, hyst=10, input 500.
  - Gain stays 4096; Lock=1 after the first window.
- **Saturation and clamp.** init=16384, gmax=16384, target=2^23-1; inputs 0x7FFFFF and 0x800000.
  - Outputs 0x7FFFFF and 0x800000; gain stays at 16384.
- **Back-to-back strobes and freeze.** Strobes on consecutive cycles across a window boundary.
  - No sample is lost: the sample coinciding with UPDATE counts in the new window (cnt=1).
  - With freeze=1 the gain never changes.
- **Mid-operation interruption.** Reduce k mid-window and drop enable mid-window.
  - Reducing k from 4 to 1 after 5 samples triggers UPDATE on the 6th.
  - Dropping enable restores the init gain on the next edge.
